argmax_arbiter: RTL and testbench
=================================

# argmax_arbiter

Round-robin scheduler that shares one `max_idx10` argmax unit (10 signed scores → winning index) between `NUM_REQ` requesters. It sits between the per-sample classifier output stages and the result consumer. Each requester presents a 10-score vector with a valid/ready handshake. The block issues one job at a time to the unit and returns the 4-bit winning index, tagged with the requester id, on a valid/ready result port.

## Interface
- `WIDTH`, 8: signed score width, passed to `max_idx10`.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: requester id width (derived, not overridden).

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high; also drives the `reset` of `max_idx10`.
- `req_valid`  in  NUM_REQ  per-requester job valid.
- `req_data`  in  NUM_REQ×10×WIDTH signed  score vectors, `req_data[r][k]`.
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts result.
- `res_idx`  out  4  argmax index 0..9.
- `res_id`  out  ID_W  requester that owns the result.
- `busy`  out  1  job in flight or result pending.
- `err`  out  1  sticky; `done` from the unit was low when the result was expected.

## Operation
- FSM `ST_IDLE` → `ST_BUSY` → `ST_RESULT` → `ST_IDLE`. Reset state is `ST_IDLE`.
- ST_IDLE, any `req_valid`:
  - grant `g` = first index ≥ `rr_ptr` with valid, wrapping.
  - assert `start` to the unit.
  - drive the unit `inputs` from `req_data[g]`.
  - assert `req_ready[g]` for that cycle only.
  - capture `res_id<=g`, set `rr_ptr<=(g+1)%NUM_REQ`, clear `cnt`, go to ST_BUSY.
- ST_BUSY: `cnt` increments each cycle. When `cnt==3` (4th cycle), go to ST_RESULT.
- ST_RESULT:
  - `res_valid=1`; `res_idx` is the unit's `idx` output.
  - on entry, if `done==0`, set `err`.
  - if `res_ready`, go to ST_IDLE. Otherwise hold, with all result outputs stable.
- `res_idx` = `res_valid ? idx : 0`. This masks the unit's unreset `idx`.
- `busy` = state != ST_IDLE.
- Requester rules: `req_valid` must not drop, and `req_data` must not change, until `req_ready`. Violations are undefined.
- Tie between equal maxima: index chosen by `max_idx10`. The block passes it through unchanged.
- `req_ready` is never asserted outside ST_IDLE. Any number of valids produces at most one grant per cycle.

## Timing
- Accept edge ends cycle t (ST_IDLE, `start=1`). The unit runs S1..S4 in t+1..t+4 (ST_BUSY).
- `res_valid` and `res_idx` are valid from cycle t+5.
- Minimum job period is 6 cycles: t+5 with `res_ready=1` → ST_IDLE at t+6 → next accept at t+6.
- Reset values: `req_ready=0`, `res_valid=0`, `res_idx=0`, `res_id=0`, `busy=0`, `err=0`, `rr_ptr=0`, `cnt=0`.
- Reset mid-job takes effect immediately, with no result emitted.
  - The unit resets synchronously, so `reset` must be held across ≥1 rising edge.
  - A job in flight is lost. The requester already saw `req_ready`, so it does not retry.
- Simultaneous `res_ready` and new `req_valid` in ST_RESULT: the request waits one cycle and is arbitrated in ST_IDLE.
- `rr_ptr` wraps `NUM_REQ-1` → 0.

## Structure
- Package `argmax_pkg`:
  - `argmax_state_t` enum {ST_IDLE, ST_BUSY, ST_RESULT}.
  - `NUM_CLASSES=10`.
  - `IDX_W=4`.
  - `ARGMAX_LAT=4` (ST_BUSY length).
- One sub-module: `max_idx10`, instantiated once with `WIDTH`.
- Round-robin pick is a function in the package, `rr_pick(valid, ptr)` returning `{found, idx}`.

## Test plan
- Single job:
  - Stimulus: req 1 valid, all scores −5 except `[7]=100`.
  - Expect: `req_ready=4'b0010` for one cycle; `res_valid` 5 cycles later; `res_idx=7`, `res_id=1`, `err=0`.
- Contention:
  - Stimulus: reqs 0..3 all valid at once, maxima at indices 3, 9, 0, 5.
  - Expect: results in order id 0,1,2,3 with idx 3,9,0,5, spaced 6 cycles with `res_ready=1`.
- Backpressure:
  - Stimulus: `res_ready=0` for 10 cycles.
  - Expect: `res_valid`, `res_idx`, `res_id` stable; no `req_ready` pulse; the pending req is accepted 1 cycle after `res_ready`.
- Signed extremes:
  - Vector with all −128 except `[9]=127` → idx 9.
  - Vector `[0]=−1`, rest −128 → idx 0.
- Fairness:
  - Stimulus: req 0 held valid continuously and req 2 valid continuously.
  - Expect: grants alternate 0,2,0,2; neither starves.
- Reset mid-job:
  - Stimulus: assert `reset` at t+2.
  - Expect: all outputs at reset values immediately; no `res_valid`; a subsequent req 3 job completes with `res_id=3` and the correct idx.

Source files
------------

// File: rtl/argmax_pkg.sv
// Shared types, constants and the round-robin picker for the argmax arbiter.
package argmax_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESULT} argmax_state_t;

    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;
    localparam int ARGMAX_LAT  = 4;
    localparam int MAX_REQ     = 16;

    // Returns {found, idx}: first valid at or after ptr, wrapping modulo n.
    function automatic logic [IDX_W:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                input logic [IDX_W-1:0]   ptr,
                                                input int                 n);
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            int j;
            j = (int'(ptr) + i) % n;
            if (i < n && !found && valid[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/max_idx10.sv
// Pipelined argmax over 10 signed scores; idx/done appear 5 cycles after start.
// Synchronous reset clears only the control bits; idx is held until the next job.
module max_idx10
    import argmax_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [NUM_CLASSES-1:0][WIDTH-1:0]      inputs,
    output logic [IDX_W-1:0]                       idx,
    output logic                                   done
);

    localparam int STAGES = ARGMAX_LAT - 1;

    logic [STAGES:0]                  vld_pipe;
    logic [NUM_CLASSES-1:0][WIDTH-1:0] s0_v;
    logic [4:0][WIDTH-1:0]            s1_v;
    logic [4:0][IDX_W-1:0]            s1_i;
    logic [2:0][WIDTH-1:0]            s2_v;
    logic [2:0][IDX_W-1:0]            s2_i;
    logic [1:0][WIDTH-1:0]            s3_v;
    logic [1:0][IDX_W-1:0]            s3_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            done     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], start};
            if (start)
                done <= 1'b0;
            else if (vld_pipe[STAGES])
                done <= 1'b1;
        end
    end

    // Left operand always carries the lower index, so >= makes ties go low.
    always_ff @(posedge clk) begin
        s0_v <= inputs;
        for (int i = 0; i < 5; i++) begin
            if ($signed(s0_v[2*i]) >= $signed(s0_v[2*i+1])) begin
                s1_v[i] <= s0_v[2*i];
                s1_i[i] <= IDX_W'(2*i);
            end else begin
                s1_v[i] <= s0_v[2*i+1];
                s1_i[i] <= IDX_W'(2*i+1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if ($signed(s1_v[2*i]) >= $signed(s1_v[2*i+1])) begin
                s2_v[i] <= s1_v[2*i];
                s2_i[i] <= s1_i[2*i];
            end else begin
                s2_v[i] <= s1_v[2*i+1];
                s2_i[i] <= s1_i[2*i+1];
            end
        end
        s2_v[2] <= s1_v[4];
        s2_i[2] <= s1_i[4];
        if ($signed(s2_v[0]) >= $signed(s2_v[1])) begin
            s3_v[0] <= s2_v[0];
            s3_i[0] <= s2_i[0];
        end else begin
            s3_v[0] <= s2_v[1];
            s3_i[0] <= s2_i[1];
        end
        s3_v[1] <= s2_v[2];
        s3_i[1] <= s2_i[2];
        if (vld_pipe[STAGES])
            idx <= ($signed(s3_v[0]) >= $signed(s3_v[1])) ? s3_i[0] : s3_i[1];
    end

endmodule

// File: rtl/argmax_arbiter.sv
// Round-robin scheduler sharing one max_idx10 unit between NUM_REQ requesters,
// one job in flight, result returned with its requester id.
module argmax_arbiter
    import argmax_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_REQ-1:0]                              req_valid,
    input  logic [NUM_REQ-1:0][NUM_CLASSES-1:0][WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                              req_ready,
    output logic                                            res_valid,
    input  logic                                            res_ready,
    output logic [IDX_W-1:0]                                res_idx,
    output logic [ID_W-1:0]                                 res_id,
    output logic                                            busy,
    output logic                                            err
);

    argmax_state_t    state;
    logic [ID_W-1:0]  rr_ptr;
    logic [1:0]       cnt;
    logic             entry;
    logic [IDX_W:0]   pick;
    logic [ID_W-1:0]  g;
    logic [ID_W-1:0]  g_next;
    logic             grant;
    logic [IDX_W-1:0] unit_idx;
    logic             unit_done;

    assign pick   = rr_pick(MAX_REQ'(req_valid), IDX_W'(rr_ptr), NUM_REQ);
    assign g      = ID_W'(pick[IDX_W-1:0]);
    assign g_next = ID_W'((int'(g) + 1) % NUM_REQ);
    // Gated by reset so req_ready reads 0 while reset is asserted.
    assign grant  = (state == ST_IDLE) && pick[IDX_W] && !reset;

    assign req_ready = grant ? (NUM_REQ'(1) << g) : '0;
    assign res_valid = (state == ST_RESULT);
    assign res_idx   = res_valid ? unit_idx : '0;
    assign busy      = (state != ST_IDLE);

    max_idx10 #(.WIDTH(WIDTH)) u_max (
        .clk    (clk),
        .reset  (reset),
        .start  (grant),
        .inputs (req_data[g]),
        .idx    (unit_idx),
        .done   (unit_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            res_id <= '0;
            cnt    <= '0;
            entry  <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        res_id <= g;
                        rr_ptr <= g_next;
                        cnt    <= '0;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'(ARGMAX_LAT - 1)) begin
                        entry <= 1'b1;
                        state <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    entry <= 1'b0;
                    if (entry && !unit_done)
                        err <= 1'b1;
                    if (res_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_arbiter.sv
// Randomized bench for argmax_arbiter against a transaction-level timing model.
module tb_argmax_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0]           req_valid;
    logic [N-1:0][9:0][W-1:0] req_data;
    logic [N-1:0]           req_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [3:0]             res_idx;
    logic [1:0]             res_id;
    logic                   busy;
    logic                   err;

    always #5 clk = ~clk;

    argmax_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_idx   (res_idx),
        .res_id    (res_id),
        .busy      (busy),
        .err       (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference state: pending requests, the single job and its due cycle.
    bit pend [N];
    int data [N][10];
    bit in_job;
    int due, e_idx, e_id, rr;
    bit did_rst;

    function automatic int ref_argmax(input int r);
        int best = 0;
        for (int k = 1; k < 10; k++)
            if (data[r][k] > data[r][best]) best = k;
        return best;
    endfunction

    function automatic int ref_pick();
        for (int i = 0; i < N; i++) begin
            int j = (rr + i) % N;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    task automatic gen_job(input int r, input int mode);
        int pos = $urandom_range(0, 9);
        for (int k = 0; k < 10; k++) begin
            case (mode)
                0:       data[r][k] = int'($urandom_range(0, 255)) - 128;
                1:       data[r][k] = (k == 9) ? 127 : -128;
                2:       data[r][k] = (k == 0) ? -1 : -128;
                default: data[r][k] = (k == pos) ? 100 : -5;
            endcase
        end
        pend[r] = 1'b1;
    endtask

    task automatic set_peak(input int r, input int pos);
        for (int k = 0; k < 10; k++)
            data[r][k] = (k == pos) ? 120 : int'($urandom_range(0, 60)) - 30;
        pend[r] = 1'b1;
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            req_valid[r] = pend[r];
            for (int k = 0; k < 10; k++)
                req_data[r][k] = W'(data[r][k]);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req_ready"}, int'(req_ready), 0);
        chk({pfx, "_res_valid"}, int'(res_valid), 0);
        chk({pfx, "_res_idx"},   int'(res_idx),   0);
        chk({pfx, "_res_id"},    int'(res_id),    0);
        chk({pfx, "_busy"},      int'(busy),      0);
        chk({pfx, "_err"},       int'(err),       0);
    endtask

    initial begin
        int g, exp_rdy;
        bit rv;
        reset     = 1'b1;
        res_ready = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int r = 0; r < N; r++) begin
            pend[r] = 1'b0;
            for (int k = 0; k < 10; k++) data[r][k] = 0;
        end
        in_job = 1'b0; rr = 0; due = 0; e_idx = 0; e_id = 0; did_rst = 1'b0;
        cyc = -1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("init");
        reset = 1'b0;

        for (cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk);
            #1;
            // Reset two cycles after an accept, held over one rising edge.
            if (!did_rst && cyc >= 400 && in_job && cyc == due - 3) begin
                reset = 1'b1;
                #1;
                chk_reset_vals("midrst");
                @(posedge clk);
                #1;
                reset   = 1'b0;
                in_job  = 1'b0;
                rr      = 0;
                did_rst = 1'b1;
            end

            if (cyc == 0) begin
                for (int k = 0; k < 10; k++) data[1][k] = (k == 7) ? 100 : -5;
                pend[1] = 1'b1;
            end
            if (cyc == 20) begin
                set_peak(0, 3); set_peak(1, 9); set_peak(2, 0); set_peak(3, 5);
            end
            if (cyc == 60) begin
                gen_job(0, 1);
                gen_job(2, 2);
            end
            if (cyc == 62) gen_job(3, 0);
            if (cyc >= 150 && cyc < 250) begin
                if (!pend[0]) gen_job(0, int'($urandom_range(0, 3)));
                if (!pend[2]) gen_job(2, int'($urandom_range(0, 3)));
            end
            if (cyc >= 250)
                for (int r = 0; r < N; r++)
                    if (!pend[r] && $urandom_range(0, 3) == 0)
                        gen_job(r, int'($urandom_range(0, 3)));

            if (cyc >= 70 && cyc < 80) res_ready = 1'b0;
            else if (cyc < 250)        res_ready = 1'b1;
            else                       res_ready = ($urandom_range(0, 2) != 0);
            drive();
            #1;

            g       = in_job ? -1 : ref_pick();
            exp_rdy = (g >= 0) ? (1 << g) : 0;
            rv      = in_job && (cyc >= due);
            chk("req_ready", int'(req_ready), exp_rdy);
            chk("res_valid", int'(res_valid), int'(rv));
            chk("res_idx",   int'(res_idx),   rv ? e_idx : 0);
            if (rv) chk("res_id", int'(res_id), e_id);
            chk("busy", int'(busy), int'(in_job));
            chk("err",  int'(err),  0);

            if (!in_job) begin
                if (g >= 0) begin
                    in_job  = 1'b1;
                    due     = cyc + 5;
                    e_idx   = ref_argmax(g);
                    e_id    = g;
                    pend[g] = 1'b0;
                    rr      = (g + 1) % N;
                end
            end else if (rv && res_ready) begin
                in_job = 1'b0;
            end
        end
        chk("midrst_seen", int'(did_rst), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
